// File: rtl/lns_add_prep.sv
// lns_add_prep
// Operand preparation stage for a logarithmic-number-system adder.
// Given two LNS operands (zero flag, sign, log2 magnitude), it produces the
// fields the following sb-function stage needs:
//   z       = -|a_log - b_log|, saturated at -2^(W-1); always <= 0
//   max     = log magnitude of the larger-magnitude operand
//   sign    = sign of the result
//   eff_sub = a_sign ^ b_sign
//   bypass  = exactly one operand is zero, so the result is the other operand
//   zero    = the result is exact zero (both operands zero, or exact cancellation)
//
// Ports
//   clk, rst                         clock (rising edge), async active-high reset
//   a_zero/a_sign/a_log              operand A
//   b_zero/b_sign/b_log              operand B
//   in_valid / in_ready              input handshake
//   out_valid / out_ready            output handshake
//   out_z, out_max, out_sign,
//   out_eff_sub, out_bypass,
//   out_zero                         result fields (from the S2 register)
//   op_count                         number of completed output handshakes (wraps)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready never looks at in_valid. While out_valid is high and
// out_ready is low, every out_* field holds its value.
//
// Pipeline: S1 captures the raw operands, S2 captures the computed fields.
// Two stages of buffering give full throughput with an unregistered
// out_ready -> in_ready path.
module lns_add_prep #(
  parameter int W  = 11,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_zero,
  input  logic          a_sign,
  input  logic [W-1:0]  a_log,
  input  logic          b_zero,
  input  logic          b_sign,
  input  logic [W-1:0]  b_log,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_z,
  output logic [W-1:0]  out_max,
  output logic          out_sign,
  output logic          out_eff_sub,
  output logic          out_bypass,
  output logic          out_zero,
  output logic [CW-1:0] op_count
);

  // Most negative z, also used as the bypass marker.
  localparam logic [W-1:0] Z_MIN = {1'b1, {(W-1){1'b0}}};
  // 2^(W-1) at W+1 bits: saturation threshold for |d|.
  localparam logic [W:0]   HALF  = {2'b01, {(W-1){1'b0}}};

  // Stage registers
  logic          r_s1_valid;
  logic          r_a_zero, r_a_sign, r_b_zero, r_b_sign;
  logic [W-1:0]  r_a_log, r_b_log;

  logic          r_s2_valid;
  logic [W-1:0]  r_z, r_max;
  logic          r_sign, r_eff_sub, r_bypass, r_zero;
  logic [CW-1:0] r_op_count;

  // Flow control
  logic w_in_ready, w_in_hs, w_out_hs, w_s1_adv;

  // in_ready is forced low while reset is held.
  assign w_in_ready = !rst && (!r_s1_valid || !r_s2_valid || out_ready);
  assign w_in_hs    = in_valid && w_in_ready;
  assign w_out_hs   = r_s2_valid && out_ready;
  assign w_s1_adv   = r_s1_valid && (!r_s2_valid || out_ready);

  // Field computation from the S1 operands
  logic [W:0]   w_d, w_abs, w_zmag, w_zneg;
  logic         w_sat, w_eff_sub;
  logic [W-1:0] w_z, w_max;
  logic         w_sign, w_bypass, w_zero;

  // Sign-extend both logs by one bit so the difference cannot overflow.
  assign w_d       = {r_a_log[W-1], r_a_log} - {r_b_log[W-1], r_b_log};
  assign w_abs     = w_d[W] ? ({(W+1){1'b0}} - w_d) : w_d;
  assign w_sat     = (w_abs > HALF);
  assign w_zmag    = w_sat ? HALF : w_abs;
  assign w_zneg    = {(W+1){1'b0}} - w_zmag;
  assign w_eff_sub = r_a_sign ^ r_b_sign;

  always_comb begin
    // Normal case: larger magnitude wins; d = 0 picks A.
    w_z      = w_zneg[W-1:0];
    w_max    = w_d[W] ? r_b_log  : r_a_log;
    w_sign   = w_d[W] ? r_b_sign : r_a_sign;
    w_bypass = 1'b0;
    w_zero   = 1'b0;
    if (r_a_zero && r_b_zero) begin
      w_z    = '0;
      w_max  = '0;
      w_sign = 1'b0;
      w_zero = 1'b1;
    end else if (r_a_zero) begin
      w_bypass = 1'b1;
      w_z      = Z_MIN;
      w_max    = r_b_log;
      w_sign   = r_b_sign;
    end else if (r_b_zero) begin
      w_bypass = 1'b1;
      w_z      = Z_MIN;
      w_max    = r_a_log;
      w_sign   = r_a_sign;
    end else if ((w_d == '0) && w_eff_sub) begin
      // Exact cancellation: z is already 0 and max is already a_log.
      w_zero = 1'b1;
      w_sign = 1'b0;
    end
  end

  // S1: raw operand capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_a_zero   <= 1'b0;
      r_a_sign   <= 1'b0;
      r_a_log    <= '0;
      r_b_zero   <= 1'b0;
      r_b_sign   <= 1'b0;
      r_b_log    <= '0;
    end else if (w_in_hs) begin
      r_s1_valid <= 1'b1;
      r_a_zero   <= a_zero;
      r_a_sign   <= a_sign;
      r_a_log    <= a_log;
      r_b_zero   <= b_zero;
      r_b_sign   <= b_sign;
      r_b_log    <= b_log;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S2: computed fields; reset clears data so outputs read 0 during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_z        <= '0;
      r_max      <= '0;
      r_sign     <= 1'b0;
      r_eff_sub  <= 1'b0;
      r_bypass   <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_z        <= w_z;
      r_max      <= w_max;
      r_sign     <= w_sign;
      r_eff_sub  <= w_eff_sub;
      r_bypass   <= w_bypass;
      r_zero     <= w_zero;
    end else if (w_out_hs) begin
      r_s2_valid <= 1'b0;
    end
  end

  // Output handshake counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_out_hs) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_s2_valid;
  assign out_z       = r_z;
  assign out_max     = r_max;
  assign out_sign    = r_sign;
  assign out_eff_sub = r_eff_sub;
  assign out_bypass  = r_bypass;
  assign out_zero    = r_zero;
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_lns_add_prep.sv
// Testbench for lns_add_prep: directed cases, stall, async reset, random
// traffic with a scoreboard, and op_count wrap.
module tb_lns_add_prep;

  localparam int W  = 11;
  localparam int CW = 16;
  localparam int RW = 2*W + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_zero, a_sign, b_zero, b_sign;
  logic [W-1:0]  a_log, b_log;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  out_z, out_max;
  logic          out_sign, out_eff_sub, out_bypass, out_zero;
  logic [CW-1:0] op_count;

  lns_add_prep #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .a_zero(a_zero), .a_sign(a_sign), .a_log(a_log),
    .b_zero(b_zero), .b_sign(b_sign), .b_log(b_log),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_max(out_max), .out_sign(out_sign),
    .out_eff_sub(out_eff_sub), .out_bypass(out_bypass), .out_zero(out_zero),
    .op_count(op_count)
  );

  logic [RW-1:0] out_pack;
  assign out_pack = {out_z, out_max, out_sign, out_eff_sub, out_bypass, out_zero};

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] model(input logic az, input logic a_s, input logic [W-1:0] al,
                                          input logic bz, input logic b_s, input logic [W-1:0] bl);
    int half, a, b, d, ad;
    logic [W-1:0] z, mx;
    logic sg, eff, byp, zr;
    half = 1 << (W-1);
    a = int'(al); if (a >= half) a -= 2*half;
    b = int'(bl); if (b >= half) b -= 2*half;
    eff = a_s ^ b_s;
    byp = 1'b0; zr = 1'b0;
    if (az && bz) begin
      z = '0; mx = '0; sg = 1'b0; zr = 1'b1;
    end else if (az) begin
      byp = 1'b1; z = W'(-half); mx = bl; sg = b_s;
    end else if (bz) begin
      byp = 1'b1; z = W'(-half); mx = al; sg = a_s;
    end else begin
      d  = a - b;
      ad = (d < 0) ? -d : d;
      if (ad > half) ad = half;
      z = W'(-ad);
      if (d >= 0) begin mx = al; sg = a_s; end
      else        begin mx = bl; sg = b_s; end
      if (d == 0 && eff) begin zr = 1'b1; sg = 1'b0; end
    end
    return {z, mx, sg, eff, byp, zr};
  endfunction

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("sb_extra", 32'(out_valid), 32'd0);
        else check("sb_result", 32'(out_pack), 32'(exp_q.pop_front()));
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(a_zero, a_sign, a_log, b_zero, b_sign, b_log));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rand_pair();
    a_zero = ($urandom_range(0, 7) == 0);
    b_zero = ($urandom_range(0, 7) == 0);
    a_sign = 1'($urandom_range(0, 1));
    b_sign = 1'($urandom_range(0, 1));
    a_log  = W'($urandom_range(0, (1 << W) - 1));
    b_log  = ($urandom_range(0, 7) == 0) ? a_log : W'($urandom_range(0, (1 << W) - 1));
  endtask

  // Presents one pair starting at posedge+1 and returns at posedge+1 after it is accepted.
  task automatic send(input logic az, input logic a_s, input logic [W-1:0] al,
                      input logic bz, input logic b_s, input logic [W-1:0] bl);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    a_zero = az; a_sign = a_s; a_log = al;
    b_zero = bz; b_sign = b_s; b_log = bl;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Returns at the negedge where out_valid is seen.
  task automatic wait_out();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (!out_valid) check("out_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic dir_check(input string pfx, input logic [W-1:0] z, input logic [W-1:0] mx,
                           input logic sg, input logic eff, input logic byp, input logic zr);
    wait_out();
    check({pfx, "_z"},    32'(out_z),       32'(z));
    check({pfx, "_max"},  32'(out_max),     32'(mx));
    check({pfx, "_sign"}, 32'(out_sign),    32'(sg));
    check({pfx, "_eff"},  32'(out_eff_sub), 32'(eff));
    check({pfx, "_byp"},  32'(out_bypass),  32'(byp));
    check({pfx, "_zero"}, 32'(out_zero),    32'(zr));
  endtask

  // Reset pulse placed mid-cycle; returns just after release.
  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  logic [RW:0] snap;
  logic        acc;
  int          idx, n0, n_stale;

  initial begin
    in_valid = 1'b0; out_ready = 1'b0;
    a_zero = 1'b0; a_sign = 1'b0; a_log = '0;
    b_zero = 1'b0; b_sign = 1'b0; b_log = '0;

    // reset state
    #3;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_op_count",  32'(op_count),  32'd0);
    check("rst_fields",    32'(out_pack),  32'd0);
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // a=+0x100, b=+0x000: latency and first count
    send(1'b0, 1'b0, 11'h100, 1'b0, 1'b0, 11'h000);
    @(negedge clk);
    check("lat_early", 32'(out_valid), 32'd0);
    dir_check("d1", 11'h700, 11'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("d1_count", 32'(op_count), 32'd1);

    // saturation, cancellation, bypass, double zero, negative d, |d| edge
    send(1'b0, 1'b0, 11'h3FF, 1'b0, 1'b1, 11'h400);
    dir_check("d2", 11'h400, 11'h3FF, 1'b0, 1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 11'h080, 1'b0, 1'b1, 11'h080);
    dir_check("d3", 11'h000, 11'h080, 1'b0, 1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b0, 11'h000, 1'b0, 1'b1, 11'h050);
    dir_check("d4", 11'h400, 11'h050, 1'b1, 1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b1, 11'h2AB, 1'b1, 1'b0, 11'h011);
    dir_check("d5", 11'h400, 11'h2AB, 1'b1, 1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b1, 11'h123, 1'b1, 1'b0, 11'h055);
    dir_check("d6", 11'h000, 11'h000, 1'b0, 1'b1, 1'b0, 1'b1);
    send(1'b0, 1'b1, 11'h010, 1'b0, 1'b0, 11'h020);
    dir_check("d7", 11'h7F0, 11'h020, 1'b0, 1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h400);
    dir_check("d8", 11'h400, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b1, 11'h055, 1'b0, 1'b1, 11'h055);
    dir_check("d9", 11'h000, 11'h055, 1'b1, 1'b0, 1'b0, 1'b0);

    // stall: 4 back-to-back pairs with out_ready low
    do_reset();
    n0 = n_out;
    @(posedge clk); #1;
    out_ready = 1'b0;
    idx = 0;
    rand_pair();
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 3) begin
        check("stall_accepts",  32'(idx),       32'd2);
        check("stall_in_ready", 32'(in_ready),  32'd0);
        check("stall_valid",    32'(out_valid), 32'd1);
        snap = {out_valid, out_pack};
      end
      if (c > 3 && c < 7) check("stall_hold", 32'({out_valid, out_pack}), 32'(snap));
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) rand_pair();
        else in_valid = 1'b0;
      end
      if (c == 6) out_ready = 1'b1;
    end
    @(negedge clk);
    check("stall_count", 32'(op_count),      32'd4);
    check("stall_nout",  32'(n_out - n0),    32'd4);
    check("stall_left",  32'(exp_q.size()),  32'd0);

    // random traffic with random backpressure
    acc = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_pair();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("rand_drain", 32'(exp_q.size()), 32'd0);

    // async reset with two pairs in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    rand_pair();
    in_valid = 1'b1;
    @(posedge clk); #1;
    rand_pair();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("inflight_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_op_count",  32'(op_count),  32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd0);
    check("arst_fields",    32'(out_pack),  32'd0);
    exp_q.delete();
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    n_stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) n_stale++;
    end
    check("arst_stale", 32'(n_stale), 32'd0);

    // op_count wrap
    do_reset();
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      rand_pair();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("wrap_full", 32'(op_count), 32'h0000FFFF);
    send(1'b0, 1'b0, 11'h001, 1'b0, 1'b0, 11'h400);
    wait_out();
    @(negedge clk);
    check("wrap_zero", 32'(op_count), 32'd0);
    check("wrap_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
